// File: rtl/button_debounce.sv
// Button debouncer with press/release strobes, long-press flag and press counter.
//
// Ports:
//   clk           - sole clock, all state updates on the rising edge
//   reset         - synchronous active-high reset
//   btn_in        - raw asynchronous button pin
//   btn_level     - debounced level, 1 = pressed
//   press_pulse   - one-cycle strobe on each accepted press
//   release_pulse - one-cycle strobe on each accepted release
//   long_press    - high while the current press has lasted >= LONG_CYCLES
//   press_count   - accepted presses, modulo 256
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        StReleased,
        StWaitPress,
        StPressed,
        StWaitRelease
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            s;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            press_pulse_q, release_pulse_q;
    logic [7:0]      count_q;
    logic            press_evt, release_evt;

    // Inversion sits after the second flop so the synchronizer sees the raw pin.
    assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (s) begin
                    state_d  = StWaitPress;
                    db_cnt_d = DW'(1);
                end
            end
            StWaitPress: begin
                if (!s) begin
                    state_d  = StReleased;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = StPressed;
                    db_cnt_d  = '0;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            StPressed: begin
                if (!s) begin
                    state_d  = StWaitRelease;
                    db_cnt_d = DW'(1);
                end
            end
            StWaitRelease: begin
                if (s) begin
                    state_d  = StPressed;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = StReleased;
                    db_cnt_d    = '0;
                    release_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d  = StReleased;
                db_cnt_d = '0;
            end
        endcase
    end

    // Hold counter runs across WAIT_RELEASE bounces so a glitch does not
    // restart long-press timing; it clears on accepted press and release.
    always_comb begin
        hold_d = hold_q;
        if (press_evt || release_evt) begin
            hold_d = '0;
        end else if ((state_q == StPressed || state_q == StWaitRelease) &&
                     hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Flops reset to the idle pin level so s starts deasserted.
            sync1_q         <= ACTIVE_LOW;
            sync2_q         <= ACTIVE_LOW;
            state_q         <= StReleased;
            db_cnt_q        <= '0;
            hold_q          <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            count_q         <= '0;
        end else begin
            sync1_q         <= btn_in;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_q          <= hold_d;
            press_pulse_q   <= press_evt;
            release_pulse_q <= release_evt;
            if (press_evt) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign btn_level     = (state_q == StPressed) || (state_q == StWaitRelease);
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_press    = (hold_q == HOLD_MAX);
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    int checks;
    int failures;
    logic [7:0] exp_count;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b1;
        ticks(3);
        reset = 1'b0;
        tick();
        exp_count = 8'd0;
        checks++;
        if (btn_level !== 1'b0) begin
            failures++; $display("FAIL reset_level got=%b exp=0", btn_level);
        end
        checks++;
        if (press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b%b exp=00", press_pulse, release_pulse);
        end
        checks++;
        if (long_press !== 1'b0) begin
            failures++; $display("FAIL reset_long got=%b exp=0", long_press);
        end
        checks++;
        if (press_count !== 8'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", press_count);
        end
    endtask

    task automatic test_press_release();
        btn_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (btn_level !== (i >= 6)) begin
                failures++; $display("FAIL press_level edge=%0d got=%b exp=%b", i, btn_level, i >= 6);
            end
            checks++;
            if (press_pulse !== (i == 6)) begin
                failures++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", i, press_pulse, i == 6);
            end
            if (i == 6) exp_count = exp_count + 8'd1;
            checks++;
            if (press_count !== exp_count) begin
                failures++; $display("FAIL press_count edge=%0d got=%0d exp=%0d", i, press_count, exp_count);
            end
        end
        btn_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (btn_level !== (i < 6)) begin
                failures++; $display("FAIL release_level edge=%0d got=%b exp=%b", i, btn_level, i < 6);
            end
            checks++;
            if (release_pulse !== (i == 6) || press_pulse !== 1'b0) begin
                failures++;
                $display("FAIL release_pulse edge=%0d got=%b/%b exp=%b/0", i, release_pulse,
                         press_pulse, i == 6);
            end
        end
    endtask

    task automatic test_glitch();
        btn_in = 1'b0;
        ticks(3);
        btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (btn_level !== 1'b0 || press_pulse !== 1'b0 || press_count !== exp_count) begin
                failures++;
                $display("FAIL glitch edge=%0d got=%b/%b/%0d exp=0/0/%0d", i, btn_level,
                         press_pulse, press_count, exp_count);
            end
        end
    endtask

    // Press held 30 cycles past btn_level rise; optional 2-cycle bounce while held.
    task automatic test_long(input bit bounce);
        btn_in = 1'b0;
        ticks(6);
        exp_count = exp_count + 8'd1;
        checks++;
        if (btn_level !== 1'b1 || press_pulse !== 1'b1) begin
            failures++;
            $display("FAIL long_start got=%b/%b exp=1/1", btn_level, press_pulse);
        end
        for (int k = 1; k <= 30; k++) begin
            if (bounce && k == 4) btn_in = 1'b1;
            if (bounce && k == 6) btn_in = 1'b0;
            tick();
            checks++;
            if (long_press !== (k >= 20)) begin
                failures++;
                $display("FAIL long_rise b=%0d k=%0d got=%b exp=%b", bounce, k, long_press, k >= 20);
            end
            checks++;
            if (btn_level !== 1'b1 || release_pulse !== 1'b0 || press_pulse !== 1'b0) begin
                failures++;
                $display("FAIL long_hold b=%0d k=%0d got=%b/%b/%b exp=1/0/0", bounce, k,
                         btn_level, release_pulse, press_pulse);
            end
        end
        btn_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (long_press !== (i < 6) || release_pulse !== (i == 6)) begin
                failures++;
                $display("FAIL long_release b=%0d edge=%0d got=%b/%b exp=%b/%b", bounce, i,
                         long_press, release_pulse, i < 6, i == 6);
            end
        end
        ticks(2);
    endtask

    task automatic do_press();
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(8);
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 8'd0;
        for (int n = 0; n < 256; n++) do_press();
        checks++;
        if (press_count !== 8'd0) begin
            failures++; $display("FAIL wrap_256 got=%0d exp=0", press_count);
        end
        do_press();
        exp_count = 8'd1;
        checks++;
        if (press_count !== exp_count) begin
            failures++; $display("FAIL wrap_257 got=%0d exp=1", press_count);
        end
    endtask

    task automatic test_reset_mid_press();
        btn_in = 1'b0;
        ticks(10);
        checks++;
        if (btn_level !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got=%b exp=1", btn_level);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (btn_level !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0 ||
            long_press !== 1'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL midrst_outs got=%b/%b/%b/%b/%0d exp=0/0/0/0/0", btn_level,
                     press_pulse, release_pulse, long_press, press_count);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (press_pulse !== (i == 6) || release_pulse !== 1'b0 || btn_level !== (i >= 6)) begin
                failures++;
                $display("FAIL midrst_repress edge=%0d got=%b/%b/%b exp=%b/0/%b", i, press_pulse,
                         release_pulse, btn_level, i == 6, i >= 6);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++; $display("FAIL midrst_count got=%0d exp=1", press_count);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 8'd0;
        reset     = 1'b1;
        btn_in    = 1'b1;
        test_reset();
        test_press_release();
        test_glitch();
        test_long(1'b0);
        test_long(1'b1);
        test_wrap();
        btn_in = 1'b1;
        ticks(10);
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000; consecutive cycles a new synchronized level must persist before acceptance (1 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 50000000; cycles a debounced press must persist before a long-press is flagged; legal range > DEBOUNCE_CYCLES.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = board button reads 0 when pressed, 0 = reads 1 when pressed.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 btn_in  input  1  raw asynchronous button pin.
REQ-007 btn_level  output  1  debounced level, 1 = pressed; drives the PIO in_port directly.
REQ-008 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-010 long_press  output  1  level; 1 while the current press has lasted >= LONG_CYCLES.
REQ-011 press_count  output  8  count of accepted presses, modulo 256.

Function
REQ-012 btn_in SHALL pass through a 2-flop synchronizer; polarity inversion (when ACTIVE_LOW=1) SHALL be applied after the second flop, giving internal signal s.
REQ-013 FSM states: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE; btn_level SHALL be 1 exactly in PRESSED and WAIT_RELEASE.
REQ-014 RELEASED: s=1 -> WAIT_PRESS with debounce counter loaded to 1; else stay.
REQ-015 WAIT_PRESS: s=0 -> RELEASED (abort, no pulse); s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; else counter increments.
REQ-016 PRESSED: s=0 -> WAIT_RELEASE with counter loaded to 1; else stay.
REQ-017 WAIT_RELEASE: s=1 -> PRESSED (abort, no pulse); s=0 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; else counter increments.
REQ-018 Net latency: with btn_in held, btn_level SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new btn_in value.
REQ-019 press_pulse SHALL be registered and high for exactly the first cycle in which btn_level = 1 after a WAIT_PRESS -> PRESSED transition; release_pulse likewise for the first cycle of btn_level = 0 after WAIT_RELEASE -> RELEASED.
REQ-020 press_count SHALL increment by 1 in the same cycle press_pulse is asserted; 255 wraps to 0.
REQ-021 A hold counter SHALL clear on entry to PRESSED from WAIT_PRESS, increment each cycle in PRESSED or WAIT_RELEASE, and saturate at LONG_CYCLES.
REQ-022 long_press SHALL assert on the cycle the hold counter reaches LONG_CYCLES; it SHALL stay high through WAIT_RELEASE glitches and clear in the same cycle release_pulse asserts.
REQ-023 Counter widths SHALL be $clog2 of their parameter plus 1; no arithmetic wrap occurs inside debounce or hold counters.
REQ-024 press_pulse and release_pulse SHALL never assert in the same cycle; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.

Reset
REQ-025 With reset=1 at a rising edge: FSM -> RELEASED; synchronizer flops, debounce and hold counters -> 0 (post-inversion idle level); btn_level, press_pulse, release_pulse, long_press -> 0; press_count -> 0.
REQ-026 Reset asserted mid-press SHALL yield btn_level = 0 with no release_pulse; if the button remains pressed after reset deasserts, a fresh debounce SHALL occur and produce one press_pulse.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-027 btn_in 1->0 held -> btn_level = 1 and press_pulse = 1 exactly 6 edges later; press_count 0->1.
REQ-028 btn_in low for 3 cycles then high -> no change on btn_level, press_pulse, or press_count.
REQ-029 Press held 30 cycles, then released -> long_press rises 20 cycles after btn_level rises; release_pulse and long_press falling coincide 6 edges after release.
REQ-030 While pressed, btn_in bounces high for 2 cycles -> btn_level stays 1, no release_pulse, long_press timing unaffected.
REQ-031 256 clean presses -> press_count returns to 0; 257th press -> 1.
REQ-032 reset pulsed for 1 cycle while pressed -> all outputs 0 next cycle; button still held -> press_pulse 6 edges after reset deasserts.
